uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller sitting between UART_RX and the system side. Owns the receiver configuration
//  (Prescale, PAR_EN, PAR_TYP) and applies changes only between frames. Tracks frame
//  activity, buffers completed frames (data + error flags) in a small FIFO behind a
//  valid/ready stream, and keeps saturating error/overrun counters.
// PARAMETERS
//  DATA_LENGTH  8  frame payload width; must match UART_RX
//  FIFO_DEPTH   4  buffered frames; power of 2, >= 2
//  CNT_W        8  width of each status counter
// PORTS
//  clk           in   1            single clock
//  rst           in   1            synchronous, active-high reset
//  cfg_wr        in   1            1-cycle config write strobe
//  cfg_prescale  in   6            requested oversampling: 8, 16 or 32 only
//  cfg_par_en    in   1            requested parity enable
//  cfg_par_typ   in   1            requested parity type (0 even, 1 odd)
//  cfg_pending   out  1            accepted write not yet applied
//  cfg_rej       out  1            1-cycle pulse: write rejected
//  RX_IN         in   1            serial line, monitored for frame start
//  Prescale      out  6            to UART_RX
//  PAR_EN        out  1            to UART_RX
//  PAR_TYP       out  1            to UART_RX
//  P_DATA        in   DATA_LENGTH  from UART_RX
//  Data_valid    in   1            from UART_RX, good-frame pulse
//  Parity_Error  in   1            from UART_RX
//  Stop_Error    in   1            from UART_RX
//  rx_data       out  DATA_LENGTH  FIFO head payload
//  rx_err        out  2            FIFO head flags {stop_err, par_err}
//  rx_valid      out  1            FIFO non-empty
//  rx_ready      in   1            consumer accepts head when rx_valid & rx_ready
//  fifo_full     out  1            FIFO holds FIFO_DEPTH entries
//  par_err_cnt   out  CNT_W        parity-error frames, saturating
//  stp_err_cnt   out  CNT_W        stop-error frames, saturating
//  ovr_cnt       out  CNT_W        frames dropped due to full FIFO, saturating
// BEHAVIOUR
//  Reset: Prescale=8, PAR_EN=0, PAR_TYP=0. FSM=IDLE, FIFO empty. All counters 0.
//   cfg_pending=0, cfg_rej=0, rx_valid=0.
//  FSM:
//   IDLE -> RECV when RX_IN==0.
//   RECV -> IDLE on frame end:
//    - Data_valid==1, or
//    - rising edge of Parity_Error or Stop_Error (edges from 1-cycle-delayed copies), or
//    - timeout: clocks in RECV reach Prescale*(DATA_LENGTH+3).
//   Timeout ends the frame with no push.
//  Config:
//   - cfg_wr with prescale not in {8,16,32}: ignored; cfg_rej pulses the next cycle.
//   - Valid cfg_wr: values latch into pending regs; cfg_pending=1.
//     A later valid cfg_wr overwrites the pending regs (last write wins).
//   - Pending values drive Prescale/PAR_EN/PAR_TYP on the first cycle with FSM==IDLE
//     and RX_IN==1. cfg_pending clears on that same edge.
//   - A write never alters the outputs during RECV.
//  Frame push (at frame end, same edge):
//   - Entry = {Stop_Error edge, Parity_Error edge, P_DATA}.
//   - Data_valid together with an error edge: exactly one entry, error bits set.
//   - par_err_cnt / stp_err_cnt increment on their edge; both may increment together.
//  FIFO:
//   - Pop on rx_valid & rx_ready; rx_data/rx_err are registered outputs of the head.
//   - Push while full and no pop: entry dropped, ovr_cnt++.
//   - Push while full with a pop in the same cycle: push accepted, no drop.
//   - Push and pop on the same edge while empty: entry stored; rx_valid=1 next cycle.
//   - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
//  Counters hold at all-ones.
//  rst mid-frame: FSM->IDLE, FIFO flushed, pending config discarded, outputs to reset values.
//  Latency:
//   - Frame end to rx_valid: 1 clk.
//   - Applicable config to Prescale update: 1 clk.
// TESTING
//  1. Reset, then 8N1 frame 0xA5 @ Prescale=8
//     -> rx_valid=1, rx_data=0xA5, rx_err=00; pop empties the FIFO.
//  2. PAR_EN=1, odd parity, frame with wrong parity bit
//     -> entry rx_err=01, par_err_cnt=1, no Data_valid push duplicated.
//  3. cfg_wr prescale=16 issued mid-frame
//     -> Prescale stays 8 until the frame ends, then becomes 16. cfg_rej on prescale=12.
//  4. rx_ready=0, send FIFO_DEPTH+2 frames
//     -> fifo_full=1, ovr_cnt=2, first 4 frames pop in order.
//  5. FIFO full, rx_ready=1 on the frame-end cycle
//     -> no drop, ovr_cnt unchanged, occupancy stays 4.
//  6. RX_IN low glitch with no frame end
//     -> timeout after Prescale*(DATA_LENGTH+3) clks, no push. rst mid-frame clears all.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-side controller: config staging, frame tracking, result FIFO, status counters
//
// Purpose:
//   Sits between UART_RX and the system side. Holds the receiver configuration and
//   only lets a new configuration reach the receiver between frames. Tracks frame
//   activity on the serial line, buffers finished frames (payload + error flags) in a
//   small FIFO behind a valid/ready stream, and keeps saturating error/overrun counters.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   cfg_wr/cfg_prescale/cfg_par_en/cfg_par_typ
//                                   configuration write strobe and requested values
//   cfg_pending                     an accepted write is waiting to be applied
//   cfg_rej                         1-cycle pulse after a write with illegal prescale
//   RX_IN                           serial line, watched for the start bit
//   Prescale/PAR_EN/PAR_TYP         active configuration driven to UART_RX
//   P_DATA/Data_valid/Parity_Error/Stop_Error
//                                   results from UART_RX
//   rx_data/rx_err/rx_valid/rx_ready
//                                   FIFO head stream; rx_err = {stop_err, par_err}
//   fifo_full                       FIFO holds FIFO_DEPTH entries
//   par_err_cnt/stp_err_cnt/ovr_cnt saturating status counters

module uart_rx_ctrl #(
  parameter int DATA_LENGTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [5:0]             cfg_prescale,
  input  logic                   cfg_par_en,
  input  logic                   cfg_par_typ,
  output logic                   cfg_pending,
  output logic                   cfg_rej,
  input  logic                   RX_IN,
  output logic [5:0]             Prescale,
  output logic                   PAR_EN,
  output logic                   PAR_TYP,
  input  logic [DATA_LENGTH-1:0] P_DATA,
  input  logic                   Data_valid,
  input  logic                   Parity_Error,
  input  logic                   Stop_Error,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic [1:0]             rx_err,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   fifo_full,
  output logic [CNT_W-1:0]       par_err_cnt,
  output logic [CNT_W-1:0]       stp_err_cnt,
  output logic [CNT_W-1:0]       ovr_cnt
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int EW         = DATA_LENGTH + 2;
  localparam int FRAME_BITS = DATA_LENGTH + 3;
  // Large enough for the slowest legal prescale (32).
  localparam int TMO_W      = $clog2(32 * FRAME_BITS + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Frame tracking
  // ---------------------------------------------------------------------------
  logic [0:0]       state;
  logic             par_d;
  logic             stp_d;
  logic             par_edge;
  logic             stp_edge;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_limit;
  logic             timeout;
  logic             in_recv;
  logic             frame_end;
  logic             push;

  // UART_RX may hold its error flags for more than one cycle; only the rising
  // edge marks the end of a frame so a frame is never counted twice.
  assign par_edge  = Parity_Error & ~par_d;
  assign stp_edge  = Stop_Error & ~stp_d;

  assign tmo_limit = TMO_W'(Prescale) * TMO_W'(FRAME_BITS);
  // tmo_cnt is 0 on the first RECV cycle, so the last allowed cycle is limit-1.
  assign timeout   = (tmo_cnt == (tmo_limit - TMO_W'(1)));

  assign in_recv   = (state == ST_RECV);
  assign frame_end = in_recv & (Data_valid | par_edge | stp_edge | timeout);
  // A bare timeout closes the frame but produces no entry.
  assign push      = in_recv & (Data_valid | par_edge | stp_edge);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_d <= 1'b0;
      stp_d <= 1'b0;
    end else begin
      par_d <= Parity_Error;
      stp_d <= Stop_Error;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (!RX_IN) begin
            state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (frame_end) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration staging
  // ---------------------------------------------------------------------------
  logic       cfg_ok;
  logic       cfg_apply;
  logic [5:0] pend_prescale;
  logic       pend_par_en;
  logic       pend_par_typ;

  assign cfg_ok    = (cfg_prescale == 6'd8) | (cfg_prescale == 6'd16) | (cfg_prescale == 6'd32);
  // Only apply on an idle, high line so a start bit is never sampled with a
  // configuration different from the rest of its frame.
  assign cfg_apply = cfg_pending & (state == ST_IDLE) & RX_IN;

  always_ff @(posedge clk) begin
    if (rst) begin
      Prescale      <= 6'd8;
      PAR_EN        <= 1'b0;
      PAR_TYP       <= 1'b0;
      pend_prescale <= 6'd8;
      pend_par_en   <= 1'b0;
      pend_par_typ  <= 1'b0;
      cfg_pending   <= 1'b0;
      cfg_rej       <= 1'b0;
    end else begin
      cfg_rej <= cfg_wr & ~cfg_ok;

      if (cfg_apply) begin
        Prescale <= pend_prescale;
        PAR_EN   <= pend_par_en;
        PAR_TYP  <= pend_par_typ;
      end

      // A write landing on the apply edge becomes the next pending value,
      // so the pending flag stays set for it.
      if (cfg_wr && cfg_ok) begin
        pend_prescale <= cfg_prescale;
        pend_par_en   <= cfg_par_en;
        pend_par_typ  <= cfg_par_typ;
        cfg_pending   <= 1'b1;
      end else if (cfg_apply) begin
        cfg_pending   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;

  assign entry     = {stp_edge, par_edge, P_DATA};
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign rx_valid  = (count != '0);
  assign pop       = rx_valid & rx_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO survives.
  assign push_ok   = push & (~fifo_full | pop);
  assign drop      = push & fifo_full & ~pop;

  assign head      = mem[rd_ptr];
  assign rx_data   = head[DATA_LENGTH-1:0];
  assign rx_err    = head[EW-1:DATA_LENGTH];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating status counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      ovr_cnt     <= '0;
    end else begin
      if (push && par_edge && (par_err_cnt != CNT_MAX)) begin
        par_err_cnt <= par_err_cnt + CNT_W'(1);
      end
      if (push && stp_edge && (stp_err_cnt != CNT_MAX)) begin
        stp_err_cnt <= stp_err_cnt + CNT_W'(1);
      end
      if (drop && (ovr_cnt != CNT_MAX)) begin
        ovr_cnt <= ovr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl

module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_wr;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic       cfg_pending;
  logic       cfg_rej;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       Parity_Error;
  logic       Stop_Error;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       fifo_full;
  logic [7:0] par_err_cnt;
  logic [7:0] stp_err_cnt;
  logic [7:0] ovr_cnt;

  int n_cmp;
  int n_err;

  int   cur_ps;
  logic cur_pen;
  logic cur_ptyp;

  uart_rx_ctrl #(.DATA_LENGTH(8), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_prescale (cfg_prescale),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_typ  (cfg_par_typ),
    .cfg_pending  (cfg_pending),
    .cfg_rej      (cfg_rej),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .P_DATA       (P_DATA),
    .Data_valid   (Data_valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error),
    .rx_data      (rx_data),
    .rx_err       (rx_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .fifo_full    (fifo_full),
    .par_err_cnt  (par_err_cnt),
    .stp_err_cnt  (stp_err_cnt),
    .ovr_cnt      (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] ps, input logic pen, input logic ptyp);
    cfg_wr       = 1'b1;
    cfg_prescale = ps;
    cfg_par_en   = pen;
    cfg_par_typ  = ptyp;
    tick();
    cfg_wr       = 1'b0;
  endtask

  // Plays one serial frame and the UART_RX result pulse in the middle of the
  // stop bit. Returns right after the result edge with the line high.
  task automatic send_frame(input logic [7:0] d, input logic perr, input logic serr,
                            input logic dv, input logic pop_end,
                            input logic mid_wr, input logic [5:0] mid_ps);
    RX_IN = 1'b0;
    repeat (cur_ps) tick();
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      if (i == 0 && mid_wr) begin
        cfg_write(mid_ps, cur_pen, cur_ptyp);
        repeat (cur_ps - 1) tick();
      end else begin
        repeat (cur_ps) tick();
      end
    end
    if (cur_pen) begin
      RX_IN = (^d) ^ cur_ptyp ^ perr;
      repeat (cur_ps) tick();
    end
    RX_IN = 1'b1;
    repeat (cur_ps / 2) tick();
    P_DATA       = d;
    Data_valid   = dv;
    Parity_Error = perr;
    Stop_Error   = serr;
    rx_ready     = pop_end;
    tick();
    Data_valid   = 1'b0;
    Parity_Error = 1'b0;
    Stop_Error   = 1'b0;
    rx_ready     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (Prescale !== 6'd8) begin n_err++; $display("FAIL reset_prescale: got %0d want 8", Prescale); end
    n_cmp++; if (PAR_EN !== 1'b0 || PAR_TYP !== 1'b0) begin n_err++; $display("FAIL reset_parity: got en=%b typ=%b want 0 0", PAR_EN, PAR_TYP); end
    n_cmp++; if (cfg_pending !== 1'b0 || cfg_rej !== 1'b0) begin n_err++; $display("FAIL reset_cfg_flags: got pend=%b rej=%b want 0 0", cfg_pending, cfg_rej); end
    n_cmp++; if (rx_valid !== 1'b0 || fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_fifo: got valid=%b full=%b want 0 0", rx_valid, fifo_full); end
    n_cmp++; if (par_err_cnt !== 8'd0 || stp_err_cnt !== 8'd0 || ovr_cnt !== 8'd0) begin n_err++; $display("FAIL reset_counters: got %0d %0d %0d want 0 0 0", par_err_cnt, stp_err_cnt, ovr_cnt); end
  endtask

  task automatic test_basic_frame();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_latency: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5 || rx_err !== 2'b00) begin n_err++; $display("FAIL basic_entry: got data=%h err=%b want a5 00", rx_data, rx_err); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop_empty: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_parity_error();
    cfg_write(6'd8, 1'b1, 1'b1);
    n_cmp++; if (cfg_pending !== 1'b1 || PAR_EN !== 1'b0) begin n_err++; $display("FAIL par_cfg_pending: got pend=%b en=%b want 1 0", cfg_pending, PAR_EN); end
    tick();
    n_cmp++; if (cfg_pending !== 1'b0 || PAR_EN !== 1'b1 || PAR_TYP !== 1'b1) begin n_err++; $display("FAIL par_cfg_applied: got pend=%b en=%b typ=%b want 0 1 1", cfg_pending, PAR_EN, PAR_TYP); end
    cur_pen  = 1'b1;
    cur_ptyp = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_err !== 2'b01) begin n_err++; $display("FAIL par_entry: got valid=%b data=%h err=%b want 1 3c 01", rx_valid, rx_data, rx_err); end
    n_cmp++; if (par_err_cnt !== 8'd1 || stp_err_cnt !== 8'd0) begin n_err++; $display("FAIL par_counters: got par=%0d stp=%0d want 1 0", par_err_cnt, stp_err_cnt); end
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL par_single_entry: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_mid_frame_cfg();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd16);
    n_cmp++; if (Prescale !== 6'd8 || cfg_pending !== 1'b1) begin n_err++; $display("FAIL midcfg_held: got ps=%0d pend=%b want 8 1", Prescale, cfg_pending); end
    tick();
    n_cmp++; if (Prescale !== 6'd16 || cfg_pending !== 1'b0) begin n_err++; $display("FAIL midcfg_applied: got ps=%0d pend=%b want 16 0", Prescale, cfg_pending); end
    cur_ps = 16;
    n_cmp++; if (rx_data !== 8'hFF || rx_err !== 2'b00) begin n_err++; $display("FAIL midcfg_entry: got data=%h err=%b want ff 00", rx_data, rx_err); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    cfg_write(6'd12, 1'b0, 1'b0);
    n_cmp++; if (cfg_rej !== 1'b1 || cfg_pending !== 1'b0) begin n_err++; $display("FAIL cfg_rej_pulse: got rej=%b pend=%b want 1 0", cfg_rej, cfg_pending); end
    tick();
    n_cmp++; if (cfg_rej !== 1'b0 || Prescale !== 6'd16) begin n_err++; $display("FAIL cfg_rej_after: got rej=%b ps=%0d want 0 16", cfg_rej, Prescale); end
    cfg_write(6'd8, 1'b0, 1'b0);
    tick();
    cur_ps   = 8;
    cur_pen  = 1'b0;
    cur_ptyp = 1'b0;
    n_cmp++; if (Prescale !== 6'd8 || PAR_EN !== 1'b0) begin n_err++; $display("FAIL cfg_restore: got ps=%0d en=%b want 8 0", Prescale, PAR_EN); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      tick();
      if (i == 2) begin
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full: got %b want 0", fifo_full); end
      end
      if (i == 3) begin
        n_cmp++; if (fifo_full !== 1'b1 || ovr_cnt !== 8'd0) begin n_err++; $display("FAIL ovf_full: got full=%b ovr=%0d want 1 0", fifo_full, ovr_cnt); end
      end
    end
    n_cmp++; if (ovr_cnt !== 8'd2 || fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_count: got ovr=%0d full=%b want 2 1", ovr_cnt, fifo_full); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL ovf_order_%0d: got valid=%b data=%h want 1 %h", i, rx_valid, rx_data, 8'h10 + 8'(i)); end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      tick();
    end
    send_frame(8'h24, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    n_cmp++; if (ovr_cnt !== 8'd2 || fifo_full !== 1'b1) begin n_err++; $display("FAIL fullpop_no_drop: got ovr=%0d full=%b want 2 1", ovr_cnt, fifo_full); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL fullpop_order_%0d: got valid=%b data=%h want 1 %h", i, rx_valid, rx_data, 8'h20 + 8'(i)); end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_drained: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_timeout_and_reset();
    // Line glitch: enters RECV on this edge, then the line returns high.
    RX_IN = 1'b0;
    tick();
    RX_IN = 1'b1;
    cfg_write(6'd16, 1'b0, 1'b0);
    repeat (87) tick();
    n_cmp++; if (Prescale !== 6'd8 || cfg_pending !== 1'b1) begin n_err++; $display("FAIL tmo_still_recv: got ps=%0d pend=%b want 8 1", Prescale, cfg_pending); end
    tick();
    n_cmp++; if (Prescale !== 6'd16 || cfg_pending !== 1'b0) begin n_err++; $display("FAIL tmo_ended: got ps=%0d pend=%b want 16 0", Prescale, cfg_pending); end
    n_cmp++; if (rx_valid !== 1'b0 || par_err_cnt !== 8'd1 || stp_err_cnt !== 8'd0) begin n_err++; $display("FAIL tmo_no_push: got valid=%b par=%0d stp=%0d want 0 1 0", rx_valid, par_err_cnt, stp_err_cnt); end
    cur_ps = 16;
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    n_cmp++; if (rx_valid !== 1'b1 || rx_err !== 2'b10 || stp_err_cnt !== 8'd1) begin n_err++; $display("FAIL stp_entry: got valid=%b err=%b stp=%0d want 1 10 1", rx_valid, rx_err, stp_err_cnt); end
    tick();
    RX_IN = 1'b0;
    tick();
    cfg_write(6'd32, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    RX_IN = 1'b1;
    cur_ps = 8;
    n_cmp++; if (rx_valid !== 1'b0 || cfg_pending !== 1'b0 || Prescale !== 6'd8) begin n_err++; $display("FAIL rst_mid_frame: got valid=%b pend=%b ps=%0d want 0 0 8", rx_valid, cfg_pending, Prescale); end
    n_cmp++; if (par_err_cnt !== 8'd0 || stp_err_cnt !== 8'd0 || ovr_cnt !== 8'd0) begin n_err++; $display("FAIL rst_counters: got %0d %0d %0d want 0 0 0", par_err_cnt, stp_err_cnt, ovr_cnt); end
    repeat (3) tick();
    n_cmp++; if (Prescale !== 6'd8 || PAR_EN !== 1'b0) begin n_err++; $display("FAIL rst_pending_discarded: got ps=%0d en=%b want 8 0", Prescale, PAR_EN); end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    cur_ps       = 8;
    cur_pen      = 1'b0;
    cur_ptyp     = 1'b0;
    rst          = 1'b1;
    cfg_wr       = 1'b0;
    cfg_prescale = 6'd8;
    cfg_par_en   = 1'b0;
    cfg_par_typ  = 1'b0;
    RX_IN        = 1'b1;
    P_DATA       = 8'h00;
    Data_valid   = 1'b0;
    Parity_Error = 1'b0;
    Stop_Error   = 1'b0;
    rx_ready     = 1'b0;

    test_reset();
    test_basic_frame();
    test_parity_error();
    test_mid_frame_cfg();
    test_overflow();
    test_full_pop();
    test_timeout_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
